// File: rtl/load_store_unit.sv
// Load/store adapter: byte/half/word requests onto a word-only, one-cycle-read memory.
// Latency: load 3, word store 2, sub-word store 4, error 2 cycles; req_ready only in IDLE (one request in flight).
module load_store_unit #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic                  resp_err,
    output logic [31:0]           resp_data,
    output logic                  mem_write_en,
    output logic [ADDR_WIDTH-1:0] mem_write_addr,
    output logic [31:0]           mem_write_data,
    output logic [ADDR_WIDTH-1:0] mem_read_addr,
    input  logic [31:0]           mem_read_data
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        DATA = 3'd2,
        WR   = 3'd3,
        ERR  = 3'd4
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    state_t                  state;
    state_t                  state_d;
    logic                    write_q;
    logic [1:0]              size_q;
    logic                    signed_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [31:0]             wdata_q;
    logic [31:0]             merge_q;

    logic                    accept;
    logic                    misaligned;
    logic [7:0]              byte_lane;
    logic [15:0]             half_lane;
    logic [31:0]             load_val;
    logic [31:0]             merged;

    assign accept = (state == IDLE) && req_valid;

    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = req_addr[0];
            SZ_WORD: misaligned = (req_addr[1:0] != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d      = state;
        req_ready    = 1'b0;
        mem_write_en = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (misaligned) begin
                        state_d = ERR;
                    end else if (req_write && (req_size == SZ_WORD)) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD:      state_d = DATA;
            DATA:    state_d = write_q ? WR : IDLE;
            WR: begin
                mem_write_en = 1'b1;
                state_d      = IDLE;
            end
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Little-endian lane selection from the word returned by memory.
    always_comb begin
        byte_lane = 8'h00;
        case (addr_q[1:0])
            2'd0:    byte_lane = mem_read_data[7:0];
            2'd1:    byte_lane = mem_read_data[15:8];
            2'd2:    byte_lane = mem_read_data[23:16];
            default: byte_lane = mem_read_data[31:24];
        endcase
        half_lane = addr_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];
    end

    always_comb begin
        load_val = mem_read_data;
        case (size_q)
            SZ_BYTE: load_val = {{24{signed_q & byte_lane[7]}}, byte_lane};
            SZ_HALF: load_val = {{16{signed_q & half_lane[15]}}, half_lane};
            default: load_val = mem_read_data;
        endcase
    end

    always_comb begin
        merged = mem_read_data;
        if (size_q == SZ_BYTE) begin
            case (addr_q[1:0])
                2'd0:    merged[7:0]   = wdata_q[7:0];
                2'd1:    merged[15:8]  = wdata_q[7:0];
                2'd2:    merged[23:16] = wdata_q[7:0];
                default: merged[31:24] = wdata_q[7:0];
            endcase
        end else if (addr_q[1]) begin
            merged[31:16] = wdata_q[15:0];
        end else begin
            merged[15:0] = wdata_q[15:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_q  <= 1'b0;
            size_q   <= 2'd0;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= 32'h0;
            merge_q  <= 32'h0;
        end else begin
            if (accept) begin
                write_q  <= req_write;
                size_q   <= req_size;
                signed_q <= req_signed;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
            end
            if ((state == DATA) && write_q) begin
                merge_q <= merged;
            end
        end
    end

    // Response registers: resp_valid pulses for one cycle, err/data hold until the next response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_data  <= 32'h0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                DATA: begin
                    if (!write_q) begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_data  <= load_val;
                    end
                end
                WR: begin
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_data  <= 32'h0;
                end
                ERR: begin
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b1;
                    resp_data  <= 32'h0;
                end
                default: ;
            endcase
        end
    end

    assign mem_read_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign mem_write_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign mem_write_data = (size_q == SZ_WORD) ? wdata_q : merge_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small one-cycle-read word memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_data;
    logic        mem_write_en;
    logic [31:0] mem_write_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_addr;
    logic [31:0] mem_read_data;

    logic [31:0] mem [0:63];
    logic        pre_en;
    logic [5:0]  pre_idx;
    logic [31:0] pre_dat;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_WIDTH(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_size       (req_size),
        .req_signed     (req_signed),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_err       (resp_err),
        .resp_data      (resp_data),
        .mem_write_en   (mem_write_en),
        .mem_write_addr (mem_write_addr),
        .mem_write_data (mem_write_data),
        .mem_read_addr  (mem_read_addr),
        .mem_read_data  (mem_read_data)
    );

    always @(posedge clk) begin
        if (pre_en) begin
            mem[pre_idx] <= pre_dat;
        end else if (mem_write_en) begin
            mem[mem_write_addr[7:2]] <= mem_write_data;
        end
        mem_read_data <= mem[mem_read_addr[7:2]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        pre_en  = 1'b1;
        pre_idx = a[7:2];
        pre_dat = d;
        @(negedge clk);
        pre_en  = 1'b0;
    endtask

    // Called at a negedge with the unit idle; returns at the negedge of the response cycle.
    task automatic txn(input string tag, input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd, input int lat, input int wr_cyc,
                       input logic [31:0] exp_wdat, input logic [31:0] exp_data, input logic exp_err);
        check({tag, ".ready_in"}, req_ready, 1'b1);
        req_valid  = 1'b1;
        req_write  = w;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk);
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            check($sformatf("%s.wen@%0d", tag, c), mem_write_en, (c == wr_cyc));
            check($sformatf("%s.rvld@%0d", tag, c), resp_valid, (c == lat));
            check($sformatf("%s.rdy@%0d", tag, c), req_ready, (c == lat));
            check($sformatf("%s.waddr@%0d", tag, c), mem_write_addr, {a[31:2], 2'b00});
            if (c == wr_cyc) check({tag, ".wdat"}, mem_write_data, exp_wdat);
            if (c == lat) begin
                check({tag, ".data"}, resp_data, exp_data);
                check({tag, ".err"}, resp_err, exp_err);
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = 2'd0;
        req_signed = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        pre_en     = 1'b0;
        pre_idx    = 6'd0;
        pre_dat    = 32'h0;
        repeat (2) @(negedge clk);
        check("rst.ready", req_ready, 1'b1);
        check("rst.rvld", resp_valid, 1'b0);
        check("rst.err", resp_err, 1'b0);
        check("rst.data", resp_data, 32'h0);
        check("rst.wen", mem_write_en, 1'b0);
        check("rst.raddr", mem_read_addr, 32'h0);
        check("rst.waddr", mem_write_addr, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // Word store then word load.
        txn("st_w", 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 2, 1, 32'hDEADBEEF, 32'h0, 0);
        check("mem10", mem[4], 32'hDEADBEEF);
        txn("ld_w", 0, 2'd2, 0, 32'h10, 32'h0, 3, 0, 32'h0, 32'hDEADBEEF, 0);

        // Byte loads with extension.
        preload(32'h20, 32'h11223344);
        txn("ldb23s", 0, 2'd0, 1, 32'h23, 32'h0, 3, 0, 32'h0, 32'h00000011, 0);
        txn("ldb21u", 0, 2'd0, 0, 32'h21, 32'h0, 3, 0, 32'h0, 32'h00000033, 0);
        txn("stb22", 1, 2'd0, 0, 32'h22, 32'h00000080, 4, 3, 32'h11803344, 32'h0, 0);
        txn("ldb22s", 0, 2'd0, 1, 32'h22, 32'h0, 3, 0, 32'h0, 32'hFFFFFF80, 0);
        txn("ldb22u", 0, 2'd0, 0, 32'h22, 32'h0, 3, 0, 32'h0, 32'h00000080, 0);

        // Sub-word read-modify-write stores; upper wdata bits must be ignored.
        preload(32'h20, 32'h11223344);
        txn("stb21", 1, 2'd0, 0, 32'h21, 32'h123456AA, 4, 3, 32'h1122AA44, 32'h0, 0);
        txn("sth22", 1, 2'd1, 0, 32'h22, 32'hFFFFBEEF, 4, 3, 32'hBEEFAA44, 32'h0, 0);
        check("mem20", mem[8], 32'hBEEFAA44);
        txn("ldh22s", 0, 2'd1, 1, 32'h22, 32'h0, 3, 0, 32'h0, 32'hFFFFBEEF, 0);
        txn("ldh20u", 0, 2'd1, 0, 32'h20, 32'h0, 3, 0, 32'h0, 32'h0000AA44, 0);
        txn("ldw20s", 0, 2'd2, 1, 32'h20, 32'h0, 3, 0, 32'h0, 32'hBEEFAA44, 0);

        // Misaligned and illegal requests.
        txn("err_h21", 0, 2'd1, 0, 32'h21, 32'h0, 2, 0, 32'h0, 32'h0, 1);
        txn("err_w22", 0, 2'd2, 0, 32'h22, 32'h0, 2, 0, 32'h0, 32'h0, 1);
        txn("err_sz3", 0, 2'd3, 0, 32'h0, 32'h0, 2, 0, 32'h0, 32'h0, 1);
        txn("err_sw21", 1, 2'd2, 0, 32'h21, 32'h55555555, 2, 0, 32'h0, 32'h0, 1);
        check("mem20_kept", mem[8], 32'hBEEFAA44);
        check("mem10_kept", mem[4], 32'hDEADBEEF);
        txn("ld_clr", 0, 2'd2, 0, 32'h10, 32'h0, 3, 0, 32'h0, 32'hDEADBEEF, 0);

        // Four word loads with req_valid held high.
        preload(32'h40, 32'hA0000001);
        preload(32'h44, 32'hA0000002);
        preload(32'h48, 32'hA0000003);
        preload(32'h4C, 32'hA0000004);
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_size   = 2'd2;
        req_signed = 1'b1;
        req_addr   = 32'h40;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            for (int c = 1; c <= 3; c++) begin
                @(negedge clk);
                check($sformatf("b2b%0d.rdy@%0d", i, c), req_ready, (c == 3));
                check($sformatf("b2b%0d.rvld@%0d", i, c), resp_valid, (c == 3));
            end
            check($sformatf("b2b%0d.data", i), resp_data, 32'hA0000001 + i);
            req_addr = 32'h44 + 4 * i;
        end
        req_valid = 1'b0;
        @(negedge clk);
        check("b2b.idle_rvld", resp_valid, 1'b0);

        // Reset during the write cycle of a byte store.
        preload(32'h30, 32'hCAFEF00D);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size  = 2'd0;
        req_addr  = 32'h31;
        req_wdata = 32'h00000011;
        @(posedge clk);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
        check("rmid.wen_before", mem_write_en, 1'b1);
        #1 reset = 1'b1;
        #1 check("rmid.wen_after", mem_write_en, 1'b0);
        check("rmid.ready", req_ready, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("rmid.rvld@%0d", c), resp_valid, 1'b0);
        end
        check("rmid.mem30", mem[12], 32'hCAFEF00D);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
